// File: rtl/info_gearbox_fifo.sv
// Wide-write / narrow-read FIFO with first-word-fall-through output, MSB sub-word first.
// Defining INFO_GEARBOX_FIFO_DATA_COUNT_EN adds registered wr_data_count / rd_data_count outputs.
module info_gearbox_fifo #(
    parameter int unsigned DIN_WIDTH        = 256,
    parameter int unsigned RATIO            = 8,
    parameter int unsigned WR_DEPTH         = 128,
    parameter int unsigned PROG_FULL_THRESH = 108,
    localparam int unsigned DOUT_WIDTH      = DIN_WIDTH / RATIO,
    localparam int unsigned CW              = $clog2(WR_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  prog_full,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  rst_busy
`ifdef INFO_GEARBOX_FIFO_DATA_COUNT_EN
    ,
    output logic [CW-1:0]         wr_data_count,
    output logic [$clog2((WR_DEPTH + 1) * RATIO):0] rd_data_count
`endif
);

    localparam int unsigned PW = $clog2(WR_DEPTH);
    localparam int unsigned IW = $clog2(RATIO);

    logic [DIN_WIDTH-1:0]  mem [WR_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DIN_WIDTH-1:0]  hold_q, hold_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [1:0]            busy_cnt_q, busy_cnt_d;
    logic                  rst_busy_q, rst_busy_d;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                  full_q, empty_q, prog_full_q, overflow_q, underflow_q;
    logic                  wr_acc, rd_acc, last_rd, load;
    logic [31:0]           shamt;

    // Next-state: storage pointers, output stage, reset-busy countdown
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        busy_cnt_d = busy_cnt_q;
        rst_busy_d = rst_busy_q;

        wr_acc  = wr_en && !full_q && !rst_busy_q;
        rd_acc  = rd_en && !empty_q && !rst_busy_q;
        last_rd = rd_acc && (idx_q == IW'(RATIO - 1));
        // Reload on the final sub-word read keeps the output stream bubble-free
        load    = (count_q != '0) && (!valid_q || last_rd);

        if (rd_acc) idx_d = idx_q + IW'(1);
        if (last_rd) valid_d = 1'b0;
        if (load) begin
            hold_d   = mem[rd_ptr_q];
            idx_d    = '0;
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        count_d = count_q + CW'(wr_acc) - CW'(load);

        if (busy_cnt_q != 2'd0) busy_cnt_d = busy_cnt_q - 2'd1;
        else                    rst_busy_d = 1'b0;

        shamt  = 32'(IW'(RATIO - 1) - idx_d) * DOUT_WIDTH;
        dout_d = valid_d ? DOUT_WIDTH'(hold_d >> shamt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            busy_cnt_q  <= 2'd2;
            rst_busy_q  <= 1'b1;
            dout_q      <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b1;
            prog_full_q <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            busy_cnt_q  <= busy_cnt_d;
            rst_busy_q  <= rst_busy_d;
            dout_q      <= dout_d;
            empty_q     <= !valid_d;
            full_q      <= rst_busy_d || (count_d == CW'(WR_DEPTH));
            prog_full_q <= rst_busy_d || (count_d >= CW'(PROG_FULL_THRESH));
            overflow_q  <= wr_en && full_q && !rst_busy_q;
            underflow_q <= rd_en && empty_q && !rst_busy_q;
        end
    end

    // Storage array is not reset; pointer reset discards its contents
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr_q] <= din;
    end

    assign dout      = dout_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign prog_full = prog_full_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign rst_busy  = rst_busy_q;

`ifdef INFO_GEARBOX_FIFO_DATA_COUNT_EN
    localparam int unsigned RCW = $clog2((WR_DEPTH + 1) * RATIO) + 1;

    logic [CW-1:0]  wr_cnt_q;
    logic [RCW-1:0] rd_cnt_q, rd_cnt_d;

    // Sub-words available: whole stored words plus what remains in the stage
    always_comb begin
        rd_cnt_d = RCW'(count_d) * RCW'(RATIO);
        if (valid_d) rd_cnt_d = rd_cnt_d + RCW'(RATIO) - RCW'(idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= count_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_data_count = wr_cnt_q;
    assign rd_data_count = rd_cnt_q;
`else
    // Count outputs not built in this configuration.
`endif

endmodule

// File: tb/tb_info_gearbox_fifo.sv
// Testbench for info_gearbox_fifo: directed table, corner sequences, and randomized run
// against a queue-based reference model.
module tb_info_gearbox_fifo;
    localparam int unsigned DW    = 256;
    localparam int unsigned R     = 8;
    localparam int unsigned DEPTH = 128;
    localparam int unsigned PFT   = 108;
    localparam int unsigned OW    = DW / R;

    logic          clk, rst, wr_en, rd_en;
    logic [DW-1:0] din;
    logic [OW-1:0] dout;
    logic          full, empty, prog_full, overflow, underflow, rst_busy;
`ifdef INFO_GEARBOX_FIFO_DATA_COUNT_EN
    logic [7:0]    wr_data_count;
    logic [11:0]   rd_data_count;
`endif

    info_gearbox_fifo #(
        .DIN_WIDTH(DW), .RATIO(R), .WR_DEPTH(DEPTH), .PROG_FULL_THRESH(PFT)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .full(full), .empty(empty), .prog_full(prog_full),
        .overflow(overflow), .underflow(underflow), .rst_busy(rst_busy)
`ifdef INFO_GEARBOX_FIFO_DATA_COUNT_EN
        , .wr_data_count(wr_data_count), .rd_data_count(rd_data_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: stored words and remaining staged sub-words as queues
    logic [DW-1:0] m_store[$];
    logic [OW-1:0] m_stage[$];
    int            m_nrst = 0;
    bit            m_ovf, m_udf, m_rst_edge;
    logic [OW-1:0] got[$];

    typedef struct {
        bit          rst, wr, rd;
        bit          busy, full, pf, empty, ovf, udf;
        bit          chk_dout;
        logic [31:0] dout;
    } vec_t;
    vec_t vt[16];

    task automatic chk_b(input string nm, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, want, $time);
        end
    endtask

    task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [DW-1:0] tagged_word(input int i);
        logic [DW-1:0] w;
        for (int k = 0; k < int'(R); k++) w[DW-1-32*k -: 32] = {16'(i), 16'(k)};
        return w;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < int'(R); k++) w[32*k +: 32] = $urandom();
        return w;
    endfunction

    function automatic vec_t mk(bit r, bit w, bit rd, bit b, bit f, bit pf, bit e,
                                bit o, bit u, bit cd, logic [31:0] d);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rd; v.busy = b; v.full = f; v.pf = pf;
        v.empty = e; v.ovf = o; v.udf = u; v.chk_dout = cd; v.dout = d;
        return v;
    endfunction

    task automatic model_edge();
        bit busy_pre, full_pre, empty_pre;
        logic [DW-1:0] w;
        busy_pre   = (m_nrst < 3);
        m_rst_edge = rst;
        if (rst) begin
            m_store.delete();
            m_stage.delete();
            m_nrst = 0;
            m_ovf  = 0;
            m_udf  = 0;
        end else begin
            full_pre  = (m_store.size() == int'(DEPTH));
            empty_pre = (m_stage.size() == 0);
            m_ovf = wr_en && full_pre && !busy_pre;
            m_udf = rd_en && empty_pre && !busy_pre;
            if (rd_en && !empty_pre && !busy_pre) void'(m_stage.pop_front());
            if (m_stage.size() == 0 && m_store.size() > 0) begin
                w = m_store.pop_front();
                for (int k = 0; k < int'(R); k++) m_stage.push_back(w[DW-1-32*k -: 32]);
            end
            if (wr_en && !full_pre && !busy_pre) m_store.push_back(din);
            if (m_nrst < 3) m_nrst++;
        end
    endtask

    task automatic model_compare();
        bit busy;
        busy = (m_nrst < 3);
        chk_b("m_rst_busy", rst_busy, busy);
        chk_b("m_full", full, busy || (m_store.size() == int'(DEPTH)));
        chk_b("m_prog_full", prog_full, busy || (m_store.size() >= int'(PFT)));
        chk_b("m_empty", empty, m_stage.size() == 0);
        chk_b("m_overflow", overflow, m_ovf);
        chk_b("m_underflow", underflow, m_udf);
        if (m_stage.size() != 0) chk_w("m_dout", dout, m_stage[0]);
        else if (m_rst_edge)     chk_w("m_dout_rst", dout, 32'd0);
`ifdef INFO_GEARBOX_FIFO_DATA_COUNT_EN
        chk_w("m_wr_data_count", 32'(wr_data_count), 32'(m_store.size()));
        chk_w("m_rd_data_count", 32'(rd_data_count), 32'(m_store.size() * int'(R) + m_stage.size()));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_compare();
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        logic [DW-1:0] pat;
        int            errs;
        int            bubbles;
        int            pw[8];
        int            pr[8];

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        for (int k = 0; k < int'(R); k++) pat[DW-1-32*k -: 32] = 32'(7 - k);

        // Reset window, single-word drain, underflow pulses
        vt[0]  = mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 1, 32'd0);
        vt[1]  = mk(0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 32'd0);
        vt[2]  = mk(0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 32'd0);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'd0);
        vt[4]  = mk(0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 32'd0);
        vt[5]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 32'd7);
        for (int k = 0; k < 7; k++) vt[6+k] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'(6 - k));
        vt[13] = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'd0);
        vt[14] = mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 32'd0);
        vt[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'd0);

        for (int i = 0; i < 16; i++) begin
            rst = vt[i].rst; wr_en = vt[i].wr; rd_en = vt[i].rd; din = pat;
            step();
            chk_b($sformatf("t%0d_busy", i), rst_busy, vt[i].busy);
            chk_b($sformatf("t%0d_full", i), full, vt[i].full);
            chk_b($sformatf("t%0d_pf", i), prog_full, vt[i].pf);
            chk_b($sformatf("t%0d_empty", i), empty, vt[i].empty);
            chk_b($sformatf("t%0d_ovf", i), overflow, vt[i].ovf);
            chk_b($sformatf("t%0d_udf", i), underflow, vt[i].udf);
            if (vt[i].chk_dout) chk_w($sformatf("t%0d_dout", i), dout, vt[i].dout);
        end

        // Fill to capacity, overflow on the 130th word, then drain in order
        do_reset();
        for (int i = 1; i <= 130; i++) begin
            wr_en = 1'b1; din = tagged_word(i);
            step();
            if (i == 108) chk_b("fill_pf_108", prog_full, 1'b0);
            if (i == 109) chk_b("fill_pf_109", prog_full, 1'b1);
            if (i == 128) chk_b("fill_full_128", full, 1'b0);
            if (i == 129) begin
                chk_b("fill_full_129", full, 1'b1);
                chk_b("fill_ovf_129", overflow, 1'b0);
            end
            if (i == 130) chk_b("fill_ovf_130", overflow, 1'b1);
        end
        wr_en = 1'b0;
        step();
        chk_b("fill_ovf_clear", overflow, 1'b0);
        got.delete();
        rd_en = 1'b1;
        repeat (1040) begin
            if (rd_en && !empty) got.push_back(dout);
            step();
        end
        rd_en = 1'b0;
        chk_w("drain_count", 32'(got.size()), 32'd1032);
        errs = 0;
        for (int j = 0; j < got.size(); j++)
            if (got[j] !== {16'(j / 8 + 1), 16'(j % 8)}) errs++;
        chk_w("drain_order_errs", 32'(errs), 32'd0);

        // One write per 8 cycles with continuous reads: no bubbles, pointers wrap
        do_reset();
        got.delete();
        bubbles = 0;
        for (int c = 0; c < 1200; c++) begin
            wr_en = (c % 8 == 0);
            din   = tagged_word(200 + c / 8);
            rd_en = (c >= 2);
            if (rd_en && !empty) got.push_back(dout);
            step();
            if (c >= 2 && (empty || underflow)) bubbles++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk_w("stream_bubbles", 32'(bubbles), 32'd0);
        chk_w("stream_reads", 32'(got.size()), 32'd1198);
        errs = 0;
        for (int j = 0; j < got.size(); j++)
            if (got[j] !== {16'(200 + j / 8), 16'(j % 8)}) errs++;
        chk_w("stream_order_errs", 32'(errs), 32'd0);

        // Reset with 50 words stored discards everything in one edge
        do_reset();
        for (int i = 0; i < 51; i++) begin
            wr_en = 1'b1; din = tagged_word(i);
            step();
        end
        wr_en = 1'b0;
        step();
        chk_b("pre_rst_empty", empty, 1'b0);
`ifdef INFO_GEARBOX_FIFO_DATA_COUNT_EN
        chk_w("pre_rst_wcount", 32'(wr_data_count), 32'd50);
`endif
        rst = 1'b1;
        step();
        chk_b("mid_rst_empty", empty, 1'b1);
        chk_b("mid_rst_full", full, 1'b1);
`ifdef INFO_GEARBOX_FIFO_DATA_COUNT_EN
        chk_w("mid_rst_rcount", 32'(rd_data_count), 32'd0);
`endif
        rst = 1'b0;
        repeat (3) step();
        chk_b("post_rst_full", full, 1'b0);
        chk_b("post_rst_empty", empty, 1'b1);

        // Randomized traffic with varying write/read pressure and rare resets
        pw = '{60, 10, 90, 20, 50, 100, 5, 40};
        pr = '{90, 100, 30, 95, 100, 20, 100, 70};
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            for (int c = 0; c < 500; c++) begin
                rst   = ($urandom_range(0, 599) == 0);
                wr_en = ($urandom_range(0, 99) < pw[ph]);
                rd_en = ($urandom_range(0, 99) < pr[ph]);
                din   = rand_word();
                step();
            end
        end
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
